parser_rr_arbiter: RTL and testbench
====================================

Name: parser_rr_arbiter

Overview:
Shares one parser instance between NUM_CH ingress channels, each carrying a metadata stream and a packet stream. Arbitration is round-robin at packet granularity. A granted channel forwards exactly one metadata beat, then its packet beats up to and including eop, before any other channel is served. The block sits in front of the parser's in_meta/in_pkt ports and keeps a packet counter and a sticky framing-error flag.

Parameters:
NUM_CH, 4, number of ingress channels (2..8)
DATA_W, 512, packet data width
EMPTY_W, 6, packet empty field width
META_W, 512, metadata width
IDX_W, $clog2(NUM_CH), channel index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_meta_data  in  NUM_CH*META_W  per-channel metadata; channel i occupies slice i
in_meta_valid  in  NUM_CH  per-channel metadata valid
in_meta_ready  out  NUM_CH  per-channel metadata ready
in_pkt_data  in  NUM_CH*DATA_W  per-channel packet data
in_pkt_valid  in  NUM_CH  packet valid
in_pkt_ready  out  NUM_CH  packet ready
in_pkt_sop  in  NUM_CH  start of packet
in_pkt_eop  in  NUM_CH  end of packet
in_pkt_empty  in  NUM_CH*EMPTY_W  empty bytes on eop beat
out_meta_data  out  META_W  to parser in_meta
out_meta_valid  out  1  metadata valid
out_meta_ready  in  1  parser metadata ready
out_pkt_data  out  DATA_W  to parser in_pkt
out_pkt_valid  out  1  packet valid
out_pkt_ready  in  1  parser packet ready
out_pkt_sop  out  1  start of packet
out_pkt_eop  out  1  end of packet
out_pkt_empty  out  EMPTY_W  empty bytes
grant_idx  out  IDX_W  currently granted channel
stats_pkt  out  32  count of packets forwarded (eop handshakes), wraps
err_sop  out  1  sticky framing error

Behaviour:
- The beat-transfer handshake is valid && ready in the same cycle. Data is held stable while valid && !ready.
- States: IDLE, META, PKT.
- Reset value of every register: state=IDLE, grant_idx=0, last=NUM_CH-1, stats_pkt=0, err_sop=0, first_beat=1.
- Reset applied mid-packet returns the block to IDLE. Any remaining beats of that packet are served only after that channel wins a later grant.
- IDLE:
  - all ready outputs 0; out_meta_valid=0; out_pkt_valid=0.
  - requests are req[i]=in_meta_valid[i].
  - If any request is present, pick the first requesting channel scanning from (last+1) mod NUM_CH upward with wrap.
  - Register the choice into grant_idx and last, and go to META next cycle. Arbitration therefore costs one cycle.
- META:
  - out_meta_* = channel grant_idx meta, combinational passthrough.
  - in_meta_ready[grant_idx] = out_meta_ready; all other ready bits 0.
  - On meta handshake: go to PKT, set first_beat=1.
- PKT:
  - out_pkt_* = channel grant_idx packet signals, combinational passthrough.
  - in_pkt_ready[grant_idx] = out_pkt_ready; all other ready bits 0; out_meta_valid=0.
  - On each handshake: if first_beat and sop=0, set err_sop=1. Clear first_beat after the first beat. The beat is still forwarded.
  - On an eop handshake: stats_pkt+1 (mod 2^32), go to IDLE.
  - A single-beat packet (sop=eop=1) completes in one PKT cycle.
- Outputs of non-granted channels are never visible downstream. in_pkt_valid on non-granted channels is ignored and those channels are back-pressured.
- Minimum per-packet overhead: 1 IDLE cycle + 1 META cycle. Steady-state throughput with one active channel sending 1-beat packets is 1 packet per 3 cycles.
- A channel raising meta_valid while its own packet is in PKT is not re-granted until after eop and a fresh IDLE arbitration.
- A granted channel that drops in_meta_valid in META holds the grant (no timeout). That is a protocol violation; no recovery is defined.
- err_sop is cleared only by rst.

Test Plan:
- Single channel: ch0 sends meta M0 plus a 3-beat packet, downstream always ready. out_meta shows M0 in cycle 2 after reset release, packet beats in cycles 3-5, stats_pkt=1, other in_*_ready=0 throughout.
- Round-robin fairness: all 4 channels continuously request 1-beat packets. Grant order is 0,1,2,3,0,1…; after 8 packets each channel has been served 2 times, stats_pkt=8.
- Back-pressure: out_pkt_ready toggles 1,0,1,0 during a 4-beat packet from ch2. Exactly 4 beats transfer, data is held stable during stalls, in_pkt_ready[2] mirrors out_pkt_ready, eop accepted on the 4th handshake.
- Skip idle channels: only ch1 and ch3 request, last=3. Grants go 1,3,1, and ch0/ch2 ready bits stay 0.
- Framing error: ch0's first packet beat has sop=0. err_sop rises the cycle after the handshake, the beat is still forwarded, and err_sop remains 1 until rst.
- Reset mid-packet: assert rst during beat 2 of a 5-beat packet. The next cycle shows state IDLE, grant_idx=0, out valids 0, stats_pkt=0, err_sop=0.

Source files
------------

// File: rtl/parser_rr_arbiter.sv
// Purpose : shares one parser between NUM_CH ingress channels, round-robin at packet granularity.
// Latency : one IDLE arbitration cycle plus one META cycle per packet, then beats pass through combinationally.
// Backpr. : only the granted channel sees the downstream ready; every other channel's ready is held at 0.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_meta_* / in_pkt_*        per-channel metadata and packet streams (channel i in slice i)
//   out_meta_* / out_pkt_*      muxed streams toward the parser
//   grant_idx                   channel currently holding the grant
//   stats_pkt                   forwarded packet count (eop handshakes), wraps at 2^32
//   err_sop                     sticky: first beat after a metadata beat arrived without sop
module parser_rr_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6,
    parameter int META_W  = 512,
    parameter int IDX_W   = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH*META_W-1:0]  in_meta_data,
    input  logic [NUM_CH-1:0]         in_meta_valid,
    output logic [NUM_CH-1:0]         in_meta_ready,
    input  logic [NUM_CH*DATA_W-1:0]  in_pkt_data,
    input  logic [NUM_CH-1:0]         in_pkt_valid,
    output logic [NUM_CH-1:0]         in_pkt_ready,
    input  logic [NUM_CH-1:0]         in_pkt_sop,
    input  logic [NUM_CH-1:0]         in_pkt_eop,
    input  logic [NUM_CH*EMPTY_W-1:0] in_pkt_empty,
    output logic [META_W-1:0]         out_meta_data,
    output logic                      out_meta_valid,
    input  logic                      out_meta_ready,
    output logic [DATA_W-1:0]         out_pkt_data,
    output logic                      out_pkt_valid,
    input  logic                      out_pkt_ready,
    output logic                      out_pkt_sop,
    output logic                      out_pkt_eop,
    output logic [EMPTY_W-1:0]        out_pkt_empty,
    output logic [IDX_W-1:0]          grant_idx,
    output logic [31:0]               stats_pkt,
    output logic                      err_sop
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_META,
        ST_PKT
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  last_q;
    logic [31:0]       stats_q;
    logic              err_q;
    logic              first_q;

    // Round-robin pick: first requester strictly after last_q, wrapping.
    // The candidate is kept one bit wider than IDX_W so the wrap test
    // also works when NUM_CH is not a power of two.
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_vld;
    logic [IDX_W:0]    cand;

    always_comb begin
        pick_idx = last_q;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = {1'b0, last_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_CH)) begin
                cand = cand - (IDX_W+1)'(NUM_CH);
            end
            if (!pick_vld && in_meta_valid[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    // Handshakes seen on the granted channel.
    logic meta_hs;
    logic pkt_hs;
    logic g_pkt_sop;
    logic g_pkt_eop;

    assign g_pkt_sop = in_pkt_sop[grant_q];
    assign g_pkt_eop = in_pkt_eop[grant_q];
    assign meta_hs   = (state_q == ST_META) && in_meta_valid[grant_q] && out_meta_ready;
    assign pkt_hs    = (state_q == ST_PKT)  && in_pkt_valid[grant_q]  && out_pkt_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_CH - 1);
            stats_q <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick_idx;
                        last_q  <= pick_idx;
                        state_q <= ST_META;
                    end
                end
                ST_META: begin
                    if (meta_hs) begin
                        first_q <= 1'b1;
                        state_q <= ST_PKT;
                    end
                end
                ST_PKT: begin
                    if (pkt_hs) begin
                        first_q <= 1'b0;
                        // Missing sop is flagged but the beat still goes through.
                        if (first_q && !g_pkt_sop) begin
                            err_q <= 1'b1;
                        end
                        if (g_pkt_eop) begin
                            stats_q <= stats_q + 32'd1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Data/empty follow the granted slice at all times; the valids and
    // framing strobes qualify them, so nothing leaks from other channels.
    always_comb begin
        in_meta_ready  = '0;
        in_pkt_ready   = '0;
        out_meta_valid = 1'b0;
        out_pkt_valid  = 1'b0;
        out_pkt_sop    = 1'b0;
        out_pkt_eop    = 1'b0;
        out_meta_data  = in_meta_data[int'(grant_q)*META_W +: META_W];
        out_pkt_data   = in_pkt_data[int'(grant_q)*DATA_W +: DATA_W];
        out_pkt_empty  = in_pkt_empty[int'(grant_q)*EMPTY_W +: EMPTY_W];
        case (state_q)
            ST_META: begin
                out_meta_valid         = in_meta_valid[grant_q];
                in_meta_ready[grant_q] = out_meta_ready;
            end
            ST_PKT: begin
                out_pkt_valid         = in_pkt_valid[grant_q];
                out_pkt_sop           = g_pkt_sop;
                out_pkt_eop           = g_pkt_eop;
                in_pkt_ready[grant_q] = out_pkt_ready;
            end
            default: ;
        endcase
    end

    assign grant_idx = grant_q;
    assign stats_pkt = stats_q;
    assign err_sop   = err_q;

endmodule

// File: tb/tb_parser_rr_arbiter.sv
module tb_parser_rr_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int MW  = 32;
    localparam int EW  = 6;
    localparam int IW  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NCH*MW-1:0]   in_meta_data  = '0;
    logic [NCH-1:0]      in_meta_valid = '0;
    logic [NCH-1:0]      in_meta_ready;
    logic [NCH*DW-1:0]   in_pkt_data   = '0;
    logic [NCH-1:0]      in_pkt_valid  = '0;
    logic [NCH-1:0]      in_pkt_ready;
    logic [NCH-1:0]      in_pkt_sop    = '0;
    logic [NCH-1:0]      in_pkt_eop    = '0;
    logic [NCH*EW-1:0]   in_pkt_empty  = '0;
    logic [MW-1:0]       out_meta_data;
    logic                out_meta_valid;
    logic                out_meta_ready = 1'b1;
    logic [DW-1:0]       out_pkt_data;
    logic                out_pkt_valid;
    logic                out_pkt_ready  = 1'b1;
    logic                out_pkt_sop;
    logic                out_pkt_eop;
    logic [EW-1:0]       out_pkt_empty;
    logic [IW-1:0]       grant_idx;
    logic [31:0]         stats_pkt;
    logic                err_sop;

    parser_rr_arbiter #(
        .NUM_CH(NCH), .DATA_W(DW), .EMPTY_W(EW), .META_W(MW), .IDX_W(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready),
        .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid), .in_pkt_ready(in_pkt_ready),
        .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop), .in_pkt_empty(in_pkt_empty),
        .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid), .out_meta_ready(out_meta_ready),
        .out_pkt_data(out_pkt_data), .out_pkt_valid(out_pkt_valid), .out_pkt_ready(out_pkt_ready),
        .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop), .out_pkt_empty(out_pkt_empty),
        .grant_idx(grant_idx), .stats_pkt(stats_pkt), .err_sop(err_sop)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_meta;
        logic [31:0]   data;
        bit            sop;
        bit            eop;
        logic [EW-1:0] empty;
        int            ch;
        bit            first;
    } item_t;

    typedef struct {
        int ch;
        int len;
        bit sop_ok;
        bit toggle;
        int exp_meta_step;
        int exp_eop_step;
        int exp_stats;
        bit exp_err;
    } vec_t;

    // Channel sources and expected downstream stream
    logic [MW-1:0] meta_q [NCH][$];
    item_t         beat_q [NCH][$];
    item_t         exp_q[$];
    bit [NCH-1:0]  pv;
    logic [NCH-1:0] hs_m, hs_p;
    int            rdy_mode;    // 0 always ready, 1 random, 2 meta ready / pkt toggling
    bit            rand_valid;
    int            exp_stats, step_no, meta_step, eop_step;
    bit            exp_err;
    int            eop_steps[$];
    bit            stall_prev;
    logic [DW-1:0] stall_data;
    int            cnt [NCH];
    int            plen [NCH][8];
    int            checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] meta_word(int ch, int p);
        return {8'hAC, 8'(ch), 8'(p), 8'hEE};
    endfunction

    function automatic item_t make_beat(int ch, int p, int b, int len, bit sop_ok);
        item_t it;
        it.is_meta = 1'b0;
        it.data    = {8'(ch), 8'(p), 8'(b), 8'h5A} ^ 32'h3C3C_0000;
        it.sop     = (b == 0) && sop_ok;
        it.eop     = (b == len - 1);
        it.empty   = (b == len - 1) ? EW'((ch * 7 + p + len) % 64) : '0;
        it.ch      = ch;
        it.first   = (b == 0);
        return it;
    endfunction

    task automatic add_packet(int ch, int p, int len, bit sop_ok);
        meta_q[ch].push_back(meta_word(ch, p));
        for (int b = 0; b < len; b++) beat_q[ch].push_back(make_beat(ch, p, b, len, sop_ok));
    endtask

    task automatic push_exp(int ch, int p, int len, bit sop_ok);
        item_t it;
        it.is_meta = 1'b1; it.data = meta_word(ch, p); it.sop = 0; it.eop = 0;
        it.empty = '0; it.ch = ch; it.first = 0;
        exp_q.push_back(it);
        for (int b = 0; b < len; b++) exp_q.push_back(make_beat(ch, p, b, len, sop_ok));
    endtask

    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            in_meta_valid[i] = meta_q[i].size() != 0;
            in_meta_data[i*MW +: MW] = (meta_q[i].size() != 0) ? meta_q[i][0] : '0;
            in_pkt_valid[i] = pv[i];
            if (beat_q[i].size() != 0) begin
                in_pkt_data[i*DW +: DW]  = beat_q[i][0].data;
                in_pkt_sop[i]            = beat_q[i][0].sop;
                in_pkt_eop[i]            = beat_q[i][0].eop;
                in_pkt_empty[i*EW +: EW] = beat_q[i][0].empty;
            end else begin
                in_pkt_data[i*DW +: DW]  = '0;
                in_pkt_sop[i]            = 1'b0;
                in_pkt_eop[i]            = 1'b0;
                in_pkt_empty[i*EW +: EW] = '0;
            end
        end
    endtask

    task automatic flush_sources();
        for (int i = 0; i < NCH; i++) begin
            meta_q[i].delete();
            beat_q[i].delete();
        end
        pv = '0;
        exp_q.delete();
        drive();
    endtask

    // Sampled on the falling edge, i.e. with the coming posedge's inputs stable.
    task automatic check_cycle();
        logic [NCH-1:0] gm;
        item_t it;
        gm = '0;
        gm[grant_idx] = 1'b1;
        hs_m = in_meta_valid & in_meta_ready;
        hs_p = in_pkt_valid & in_pkt_ready;
        chk("ready_excl", (in_meta_ready | in_pkt_ready) & ~gm, 0);
        chk("stats", stats_pkt, exp_stats);
        chk("err_sop", err_sop, exp_err);
        if (stall_prev) chk("stall_hold", out_pkt_data, stall_data);
        if (out_pkt_valid) chk("rdy_mirror", in_pkt_ready[grant_idx], out_pkt_ready);
        if (out_meta_valid && out_meta_ready) begin
            meta_step = step_no;
            if (exp_q.size() == 0) chk("unexp_meta", 1, 0);
            else begin
                it = exp_q.pop_front();
                chk("meta_kind", it.is_meta, 1);
                chk("meta_ch", grant_idx, it.ch);
                chk("meta_data", out_meta_data, it.data);
            end
        end
        if (out_pkt_valid && out_pkt_ready) begin
            if (exp_q.size() == 0) chk("unexp_pkt", 1, 0);
            else begin
                it = exp_q.pop_front();
                chk("pkt_kind", it.is_meta, 0);
                chk("pkt_ch", grant_idx, it.ch);
                chk("pkt_data", out_pkt_data, it.data);
                chk("pkt_sop", out_pkt_sop, it.sop);
                chk("pkt_eop", out_pkt_eop, it.eop);
                if (it.eop) chk("pkt_empty", out_pkt_empty, it.empty);
                if (it.first && !it.sop) exp_err = 1'b1;
                if (it.eop) begin
                    exp_stats++;
                    eop_step = step_no;
                    eop_steps.push_back(step_no);
                end
            end
        end
        stall_prev = out_pkt_valid && !out_pkt_ready;
        stall_data = out_pkt_data;
    endtask

    task automatic advance();
        for (int i = 0; i < NCH; i++) begin
            if (hs_m[i]) void'(meta_q[i].pop_front());
            if (hs_p[i]) void'(beat_q[i].pop_front());
            if (!(pv[i] && !hs_p[i]))
                pv[i] = (beat_q[i].size() != 0) && (!rand_valid || $urandom_range(0, 3) != 0);
        end
        case (rdy_mode)
            1: begin
                out_meta_ready = $urandom_range(0, 3) != 0;
                out_pkt_ready  = $urandom_range(0, 3) != 0;
            end
            2: begin
                out_meta_ready = 1'b1;
                out_pkt_ready  = ~out_pkt_ready;
            end
            default: begin
                out_meta_ready = 1'b1;
                out_pkt_ready  = 1'b1;
            end
        endcase
        drive();
    endtask

    task automatic step();
        @(negedge clk);
        step_no++;
        check_cycle();
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic drain(input int max_steps);
        int n = 0;
        while (exp_q.size() != 0 && n < max_steps) begin
            step();
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        flush_sources();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_stats = 0; exp_err = 0; stall_prev = 0;
    endtask

    // Reference: serve channels in round-robin order over those with packets left,
    // starting after channel NCH-1 (state right after reset).
    task automatic run_stream(input int max_steps);
        int rem [NCH];
        int nxt [NCH];
        int prev, total, c;
        bit found;
        total = 0;
        for (int i = 0; i < NCH; i++) begin
            for (int p = 0; p < cnt[i]; p++) add_packet(i, p, plen[i][p], 1'b1);
            rem[i] = cnt[i]; nxt[i] = 0; total += cnt[i];
            pv[i] = beat_q[i].size() != 0;
        end
        prev = NCH - 1;
        for (int n = 0; n < total; n++) begin
            found = 0;
            for (int k = 1; k <= NCH; k++) begin
                c = (prev + k) % NCH;
                if (!found && rem[c] > 0) begin
                    push_exp(c, nxt[c], plen[c][nxt[c]], 1'b1);
                    nxt[c]++; rem[c]--; prev = c; found = 1;
                end
            end
        end
        drive();
        step_no = 0;
        eop_steps.delete();
        drain(max_steps);
        chk("stream_stats", stats_pkt, total);
        chk("stream_err", err_sop, 0);
    endtask

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{ch:0, len:3, sop_ok:1, toggle:0, exp_meta_step:2, exp_eop_step:5, exp_stats:1, exp_err:0};
        vecs[1] = '{ch:2, len:4, sop_ok:1, toggle:1, exp_meta_step:2, exp_eop_step:9, exp_stats:2, exp_err:0};
        vecs[2] = '{ch:1, len:1, sop_ok:1, toggle:0, exp_meta_step:2, exp_eop_step:3, exp_stats:3, exp_err:0};
        vecs[3] = '{ch:3, len:2, sop_ok:1, toggle:0, exp_meta_step:2, exp_eop_step:4, exp_stats:4, exp_err:0};
        vecs[4] = '{ch:0, len:2, sop_ok:0, toggle:0, exp_meta_step:2, exp_eop_step:4, exp_stats:5, exp_err:1};
        vecs[5] = '{ch:1, len:1, sop_ok:1, toggle:0, exp_meta_step:2, exp_eop_step:3, exp_stats:6, exp_err:1};
        rdy_mode = 0; rand_valid = 0;
        exp_stats = 0; exp_err = 0; stall_prev = 0; step_no = 0;

        // Reset state, held in reset
        rst = 1'b1;
        flush_sources();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant_idx, 0);
        chk("rst_stats", stats_pkt, 0);
        chk("rst_err", err_sop, 0);
        chk("rst_valids", {out_meta_valid, out_pkt_valid}, 0);
        chk("rst_readies", {in_meta_ready, in_pkt_ready}, 0);
        rst = 1'b0;

        // Directed single-packet table, no reset in between
        for (int v = 0; v < 6; v++) begin
            rdy_mode = vecs[v].toggle ? 2 : 0;
            out_meta_ready = 1'b1;
            out_pkt_ready  = 1'b1;
            add_packet(vecs[v].ch, v, vecs[v].len, vecs[v].sop_ok);
            push_exp(vecs[v].ch, v, vecs[v].len, vecs[v].sop_ok);
            pv[vecs[v].ch] = 1'b1;
            drive();
            step_no = 0; meta_step = -1; eop_step = -1;
            drain(40);
            chk("vec_meta_step", meta_step, vecs[v].exp_meta_step);
            chk("vec_eop_step", eop_step, vecs[v].exp_eop_step);
            chk("vec_stats", stats_pkt, vecs[v].exp_stats);
            chk("vec_err", err_sop, vecs[v].exp_err);
        end

        // Reset in the middle of a 5-beat packet on ch1
        rdy_mode = 0;
        add_packet(1, 9, 5, 1'b1);
        push_exp(1, 9, 5, 1'b1);
        pv[1] = 1'b1;
        drive();
        step_no = 0;
        repeat (3) step();
        @(negedge clk);
        chk("mid_beat_valid", out_pkt_valid, 1);
        chk("mid_beat_data", out_pkt_data, make_beat(1, 9, 1, 5, 1'b1).data);
        rst = 1'b1;
        @(posedge clk);
        #1;
        flush_sources();
        chk("mrst_valids", {out_meta_valid, out_pkt_valid}, 0);
        chk("mrst_readies", {in_meta_ready, in_pkt_ready}, 0);
        chk("mrst_grant", grant_idx, 0);
        chk("mrst_stats", stats_pkt, 0);
        chk("mrst_err", err_sop, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_stats = 0; exp_err = 0; stall_prev = 0;

        // Fairness: all four channels, two 1-beat packets each
        reset_dut();
        rdy_mode = 0; rand_valid = 0;
        for (int i = 0; i < NCH; i++) begin
            cnt[i] = 2;
            plen[i][0] = 1; plen[i][1] = 1;
        end
        run_stream(200);
        chk("rr_stats8", stats_pkt, 8);
        chk("rr_eops", eop_steps.size(), 8);
        for (int k = 0; k + 1 < eop_steps.size(); k++)
            chk("rr_gap", eop_steps[k+1] - eop_steps[k], 3);

        // Only ch1 and ch3 request: order 1,3,1
        reset_dut();
        cnt = '{0, 2, 0, 1};
        plen[1][0] = 2; plen[1][1] = 1; plen[3][0] = 3;
        run_stream(200);
        chk("skip_stats", stats_pkt, 3);

        // Randomized traffic and back-pressure
        for (int r = 0; r < 6; r++) begin
            reset_dut();
            rdy_mode = 1; rand_valid = 1;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] = $urandom_range(0, 5);
                for (int p = 0; p < 8; p++) plen[i][p] = $urandom_range(1, 4);
            end
            run_stream(3000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
